// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and helpers for the two-requester round-robin mux arbiter.
// State encodings are fixed so the bench and waveforms can name them.
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_t;

  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;

  function automatic arb_state_t f_other(input arb_state_t s);
    unique case (s)
      ST_G0:   f_other = ST_G1;
      ST_G1:   f_other = ST_G0;
      default: f_other = ST_IDLE;
    endcase
  endfunction

  function automatic arb_state_t f_grant_of(input logic side);
    f_grant_of = side ? ST_G1 : ST_G0;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2to1.sv
// Single-bit 2:1 mux cell; the arbiter tiles W of these for its datapath.
module mux2to1 (
  input  logic i_sel,
  input  logic i_d1,
  input  logic i_d0,
  output logic o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter owning the select of a W-bit 2:1 mux, with
// registered one-hot grants and a bounded tenure while the peer waits.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [W-1:0] f,
  output logic         busy
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] C_TOP = CW'(MAX_HOLD - 1);

  arb_state_t    r_state;
  arb_state_t    w_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_sel;

  logic          w_own;
  logic          w_oth;
  logic          w_enter;

  assign w_own = (r_state == ST_G1) ? req1 : req0;
  assign w_oth = (r_state == ST_G1) ? req0 : req1;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (req0 && req1)
          w_nxt = f_grant_of(!r_last);
        else if (req0)
          w_nxt = ST_G0;
        else if (req1)
          w_nxt = ST_G1;
        else
          w_nxt = ST_IDLE;
      end
      ST_G0, ST_G1: begin
        if (!w_own)
          w_nxt = w_oth ? f_other(r_state) : ST_IDLE;
        else if (w_oth && (r_cnt == C_TOP))
          w_nxt = f_other(r_state);
        else
          w_nxt = r_state;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign w_enter = (w_nxt != r_state) && (w_nxt != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if ((w_nxt == ST_IDLE) || w_enter)
        r_cnt <= '0;
      else if (r_cnt != C_TOP)
        r_cnt <= r_cnt + 1'b1;
      // sel only moves on a new grant, so it rests quietly while idle
      if (w_enter) begin
        r_last <= (w_nxt == ST_G1);
        r_sel  <= (w_nxt == ST_G1);
      end
    end
  end

  assign gnt0 = (r_state == ST_G0);
  assign gnt1 = (r_state == ST_G1);
  assign busy = gnt0 | gnt1;
  assign sel  = r_sel;

  for (genvar k = 0; k < W; k++) begin : g_mux
    mux2to1 u_mux (
      .i_sel (r_sel),
      .i_d1  (i1[k]),
      .i_d0  (i0[k]),
      .o_y   (f[k])
    );
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed plus random bench for mux2_rr_arbiter against an owner/tenure model.
module tb_mux2_rr_arbiter;

  localparam int W  = 8;
  localparam int MH = 4;

  logic         clk;
  logic         rst;
  logic         req0;
  logic         req1;
  logic [W-1:0] i0;
  logic [W-1:0] i1;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic [W-1:0] f;
  logic         busy;

  int n_vec;
  int n_err;

  int m_own;
  int m_ten;
  int m_last;
  int m_sel;

  mux2_rr_arbiter #(.W(W), .MAX_HOLD(MH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .i0   (i0),
    .i1   (i1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .sel  (sel),
    .f    (f),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_ten  = 0;
    m_last = 1;
    m_sel  = 0;
  endtask

  task automatic model_edge(input bit r0, input bit r1);
    bit rq [2];
    int w;
    rq[0] = r0;
    rq[1] = r1;
    if (m_own < 0) begin
      if (r0 && r1) w = 1 - m_last;
      else if (r0)  w = 0;
      else if (r1)  w = 1;
      else          w = -1;
    end else if (!rq[m_own]) begin
      w = rq[1 - m_own] ? 1 - m_own : -1;
    end else if (rq[1 - m_own] && m_ten >= MH) begin
      w = 1 - m_own;
    end else begin
      w = m_own;
    end
    if (w >= 0 && w != m_own) begin
      m_ten  = 1;
      m_last = w;
      m_sel  = w;
    end else if (w >= 0) begin
      m_ten++;
    end
    m_own = w;
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] ef;
    ef = (m_sel != 0) ? i1 : i0;
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(m_own == 0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(m_own == 1));
    chk({tag, ".busy"}, 32'(busy), 32'(m_own >= 0));
    chk({tag, ".sel"},  32'(sel),  32'(m_sel != 0));
    chk({tag, ".f"},    32'(f),    32'(ef));
    chk({tag, ".both"}, 32'(gnt0 & gnt1), 32'd0);
  endtask

  task automatic step(input bit r0, input bit r1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input string tag);
    req0 = r0;
    req1 = r1;
    i0   = d0;
    i1   = d1;
    @(posedge clk);
    model_edge(r0, r1);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();

    rst  = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    i0   = 8'hA5;
    i1   = 8'h3C;
    #1;
    check_all("t1_rst0");
    @(posedge clk);
    @(negedge clk);
    check_all("t1_rst1");
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      step(1, 1, 8'hA5, 8'h3C, "t2");
      chk("t2_gnt0", 32'(gnt0), 32'(((k / MH) % 2) == 0));
      chk("t2_f", 32'(f), ((k / MH) % 2) == 0 ? 32'hA5 : 32'h3C);
    end

    for (int k = 0; k < 10; k++) begin
      step(0, 1, 8'h11, 8'h22, "t3");
      chk("t3_gnt1", 32'(gnt1), 32'd1);
      chk("t3_sel", 32'(sel), 32'd1);
    end

    step(0, 0, 8'h44, 8'h55, "t5");
    chk("t5_sel", 32'(sel), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    step(0, 0, 8'h66, 8'h77, "t5b");
    chk("t5b_sel", 32'(sel), 32'd1);

    step(0, 1, 8'h01, 8'h02, "t6_pre");
    chk("t6_pre_gnt1", 32'(gnt1), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_gnt1", 32'(gnt1), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sel", 32'(sel), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("t6_held");

    step(1, 1, 8'hA5, 8'h3C, "t6_tie");
    chk("t6_tie_gnt0", 32'(gnt0), 32'd1);
    step(1, 1, 8'hA5, 8'h3C, "t4_a");
    step(0, 1, 8'hA5, 8'h3C, "t4_b");
    chk("t4_gnt1", 32'(gnt1), 32'd1);
    chk("t4_gnt0", 32'(gnt0), 32'd0);
    chk("t4_f", 32'(f), 32'h3C);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           W'($urandom), W'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
